reg_scan_checker: RTL
=====================

REG_SCAN_CHECKER -- requirements
Module: reg_scan_checker

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of registers scanned.
REQ-002 SHALL have parameter CYCLE_W, default 8, width of the run-cycle count.
REQ-003 SHALL have port clock  in  1  the single clock, with all state on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  a one-cycle pulse that begins a run, honoured only in IDLE.
REQ-006 SHALL have port num_cycles  in  CYCLE_W  the run length in clock cycles, latched on start.
REQ-007 SHALL have ports rwe in 1, rd in 5 and rdata in 32, which observe regfile writes.
REQ-008 SHALL have port rs1_cpu  in  5  the processor's read-port-A select.
REQ-009 SHALL have port rs1_out  out  5  the muxed read-port-A select driven to the regfile.
REQ-010 SHALL have port regA  in  32  the regfile read-port-A data, a combinational read.
REQ-011 SHALL have ports exp_addr out 5 and exp_data in 32, an expected-value ROM with 1-cycle read latency.
REQ-012 SHALL have status ports test_mode, done and pass (out, 1 each) and error_count (out, 6).
REQ-013 SHALL have failure ports fail_valid out 1, fail_reg out 5, and fail_exp / fail_act out 32.
REQ-014 SHALL have write-trace ports trace_valid out 1, trace_cycle out CYCLE_W, trace_reg out 5 and trace_data out 32.

Function
REQ-015 SHALL implement the states IDLE, RUN, SCAN_ADDR, SCAN_CMP and DONE.
REQ-016 SHALL move IDLE->RUN on start when the latched num_cycles is nonzero, and IDLE->SCAN_ADDR on start when it is zero.
REQ-017 SHALL remain in RUN for exactly num_cycles clocks, counting with cycle_cnt from 0, then enter SCAN_ADDR.
REQ-018 SHALL assert test_mode in SCAN_ADDR and SCAN_CMP only, and SHALL drive rs1_out = test_mode ? idx : rs1_cpu combinationally.
REQ-019 SHALL drive exp_addr=idx in SCAN_ADDR; SCAN_CMP then compares exp_data against regA with rs1_out held at idx.
REQ-020 SHALL, on mismatch in SCAN_CMP: increment error_count, and pulse fail_valid for 1 cycle with fail_reg=idx, fail_exp and fail_act.
REQ-021 SHALL go SCAN_CMP->SCAN_ADDR with idx+1 while idx<NUM_REGS-1, otherwise ->DONE, giving a scan of exactly 2*NUM_REGS cycles.
REQ-022 SHALL compare register 0 like every other register, with no special-casing.
REQ-023 SHALL hold done=1 in DONE with pass=(error_count==0), and SHALL take DONE->IDLE on the next start while clearing error_count.
REQ-024 SHALL ignore start in RUN, SCAN_ADDR and SCAN_CMP.
REQ-025 SHALL ignore rwe outside RUN.
REQ-026 SHALL leave error_count and pass unchanged during the start cycle in DONE, updating them only in later cycles.
REQ-027 SHALL hold error_count ≤ NUM_REGS, which needs no saturation logic.

Reset
REQ-028 SHALL, on reset low, immediately force: state IDLE, test_mode=0, rs1_out=rs1_cpu, idx=0, cycle_cnt=0.
REQ-029 SHALL, on reset low, immediately force: error_count=0, done=0, pass=0, fail_valid=0, all fail_* values 0 and all trace_* values 0.
REQ-030 SHALL abandon a run or scan on reset mid-operation, with no partial result retained.

Configuration
REQ-031 SHALL use the macro REG_SCAN_CHECKER_TRACE_EN to enable write tracing.
REQ-032 SHALL, with REG_SCAN_CHECKER_TRACE_EN defined, in RUN with rwe=1 and rd!=0, register trace_valid=1 one cycle later, with trace_cycle=cycle_cnt, trace_reg=rd and trace_data=rdata.
REQ-033 SHALL, without REG_SCAN_CHECKER_TRACE_EN, tie all trace_* outputs to 0 and leave the remaining behaviour unchanged.

Structure
REQ-034 SHALL place the state enum, NUM_REGS_DEF=32 and DEFAULT_CYCLES=100 in shared package checker_pkg.
REQ-035 SHALL implement the trace capture (REQ-032) as sub-module reg_write_tracer, instantiated only under the macro.

Verification
REQ-036 SHALL verify: num_cycles=4, start, and a ROM holding all registers equal to the regfile -> RUN lasts 4 cycles, the scan lasts 64 cycles, then done=1, pass=1, error_count=0.
REQ-037 SHALL verify: a ROM with r5 expected 7 while regfile r5=9 -> one fail_valid pulse with fail_reg=5, fail_exp=7, fail_act=9, then error_count=1 and pass=0.
REQ-038 SHALL verify: num_cycles=0 with start -> the next cycle enters SCAN_ADDR, test_mode=1 and rs1_out=0.
REQ-039 SHALL verify: reset low at scan idx=12 -> test_mode=0 and rs1_out=rs1_cpu with no clock edge, and state IDLE after reset is released.
REQ-040 SHALL verify with TRACE_EN: rwe=1, rd=3, rdata=42 at cycle_cnt=2 -> next cycle trace_valid=1, trace_cycle=2, trace_reg=3, trace_data=42.
REQ-041 SHALL verify with TRACE_EN: rd=0 produces no trace_valid.
REQ-042 SHALL verify: start re-pulsed mid-scan -> ignored, with the scan completing exactly as in REQ-036.

Source files
------------

// File: rtl/checker_pkg.sv
// Shared types and constants for the register scan checker.
package checker_pkg;

  localparam int unsigned NUM_REGS_DEF   = 32;
  localparam int unsigned DEFAULT_CYCLES = 100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SCAN_ADDR,
    ST_SCAN_CMP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/reg_write_tracer.sv
// Captures regfile writes seen during a run, tagged with the run cycle.
module reg_write_tracer #(
  parameter int unsigned CYCLE_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_run,
  input  logic               i_rwe,
  input  logic [4:0]         i_rd,
  input  logic [31:0]        i_rdata,
  input  logic [CYCLE_W-1:0] i_cycle,
  output logic               o_valid,
  output logic [CYCLE_W-1:0] o_cycle,
  output logic [4:0]         o_reg,
  output logic [31:0]        o_data
);

  logic w_hit;

  // Writes to r0 are architecturally discarded, so they are not traced.
  assign w_hit = i_run && i_rwe && (i_rd != 5'd0);

  // One-cycle valid pulse per traced write; payload holds until the next hit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_valid <= 1'b0;
      o_cycle <= '0;
      o_reg   <= '0;
      o_data  <= '0;
    end else begin
      o_valid <= w_hit;
      if (w_hit) begin
        o_cycle <= i_cycle;
        o_reg   <= i_rd;
        o_data  <= i_rdata;
      end
    end
  end

endmodule

// File: rtl/reg_scan_checker.sv
// Runs the core for a programmed number of cycles, then scans every register
// through read port A and compares against an expected-value ROM.
// Optional write tracing is enabled by defining REG_SCAN_CHECKER_TRACE_EN.
module reg_scan_checker
  import checker_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned CYCLE_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CYCLE_W-1:0] num_cycles,
  input  logic               rwe,
  input  logic [4:0]         rd,
  input  logic [31:0]        rdata,
  input  logic [4:0]         rs1_cpu,
  output logic [4:0]         rs1_out,
  input  logic [31:0]        regA,
  output logic [4:0]         exp_addr,
  input  logic [31:0]        exp_data,
  output logic               test_mode,
  output logic               done,
  output logic               pass,
  output logic [5:0]         error_count,
  output logic               fail_valid,
  output logic [4:0]         fail_reg,
  output logic [31:0]        fail_exp,
  output logic [31:0]        fail_act,
  output logic               trace_valid,
  output logic [CYCLE_W-1:0] trace_cycle,
  output logic [4:0]         trace_reg,
  output logic [31:0]        trace_data
);

  state_t             r_state, w_state_nxt;
  logic [CYCLE_W-1:0] r_ncyc;
  logic [CYCLE_W-1:0] r_cyc;
  logic [4:0]         r_idx;
  logic [5:0]         r_err;
  logic               r_fail_valid;
  logic [4:0]         r_fail_reg;
  logic [31:0]        r_fail_exp;
  logic [31:0]        r_fail_act;
  logic               w_last;
  logic               w_mismatch;

  assign w_last     = (r_idx >= 5'(NUM_REGS - 1));
  assign w_mismatch = (exp_data != regA);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    test_mode   = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (num_cycles != '0) ? ST_RUN : ST_SCAN_ADDR;
      end
      ST_RUN: begin
        if (r_cyc == r_ncyc - CYCLE_W'(1)) w_state_nxt = ST_SCAN_ADDR;
      end
      ST_SCAN_ADDR: begin
        test_mode   = 1'b1;
        w_state_nxt = ST_SCAN_CMP;
      end
      ST_SCAN_CMP: begin
        test_mode   = 1'b1;
        w_state_nxt = w_last ? ST_DONE : ST_SCAN_ADDR;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Run counter, scan index, error tally and failure report.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ncyc       <= '0;
      r_cyc        <= '0;
      r_idx        <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_reg   <= '0;
      r_fail_exp   <= '0;
      r_fail_act   <= '0;
    end else begin
      r_fail_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ncyc <= num_cycles;
            r_cyc  <= '0;
            r_idx  <= '0;
            r_err  <= '0;
          end
        end
        ST_RUN: r_cyc <= r_cyc + CYCLE_W'(1);
        ST_SCAN_CMP: begin
          if (w_mismatch) begin
            r_err        <= r_err + 6'd1;
            r_fail_valid <= 1'b1;
            r_fail_reg   <= r_idx;
            r_fail_exp   <= exp_data;
            r_fail_act   <= regA;
          end
          if (!w_last) r_idx <= r_idx + 5'd1;
        end
        ST_DONE: begin
          // Clear is registered so the start cycle still shows the result.
          if (start) begin
            r_err <= '0;
            r_idx <= '0;
            r_cyc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rs1_out     = test_mode ? r_idx : rs1_cpu;
  assign exp_addr    = r_idx;
  assign pass        = done && (r_err == '0);
  assign error_count = r_err;
  assign fail_valid  = r_fail_valid;
  assign fail_reg    = r_fail_reg;
  assign fail_exp    = r_fail_exp;
  assign fail_act    = r_fail_act;

`ifdef REG_SCAN_CHECKER_TRACE_EN
  reg_write_tracer #(
    .CYCLE_W (CYCLE_W)
  ) u_tracer (
    .clock   (clock),
    .reset   (reset),
    .i_run   (r_state == ST_RUN),
    .i_rwe   (rwe),
    .i_rd    (rd),
    .i_rdata (rdata),
    .i_cycle (r_cyc),
    .o_valid (trace_valid),
    .o_cycle (trace_cycle),
    .o_reg   (trace_reg),
    .o_data  (trace_data)
  );
`else
  logic w_unused_trace;
  assign w_unused_trace = ^{rwe, rd, rdata};
  assign trace_valid    = 1'b0;
  assign trace_cycle    = '0;
  assign trace_reg      = '0;
  assign trace_data     = '0;
`endif

endmodule
